// File: rtl/kl_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : kl_request_scheduler
// Description : Queues BWT occurrence-fetch requests (k/l address pair plus
//               read tag) and serialises them onto one memory request port,
//               k first then l. Backpressures the pipeline through stall and
//               limits in-flight memory reads with a credit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module kl_request_scheduler #(
    parameter int ADDR_W  = 42,
    parameter int TAG_W   = 9,
    parameter int DEPTH   = 16,
    parameter int SLACK   = 2,
    parameter int MAX_OUT = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    input  logic [ADDR_W-1:0]          req_addr_k,
    input  logic [ADDR_W-1:0]          req_addr_l,
    input  logic [TAG_W-1:0]           req_read_num,
    output logic                       stall,
    output logic                       mem_req_valid,
    input  logic                       mem_req_ready,
    output logic [ADDR_W-1:0]          mem_req_addr,
    output logic [TAG_W:0]             mem_req_tag,
    input  logic                       mem_rsp_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic [$clog2(MAX_OUT):0]   outstanding,
    output logic                       busy,
    output logic                       rsp_err
);

    localparam int c_PW = $clog2(DEPTH);
    localparam int c_CW = c_PW + 1;
    localparam int c_OW = $clog2(MAX_OUT) + 1;

    // Stall threshold keeps SLACK entries free for requests already in flight
    // in the pipeline when it sees stall.
    localparam logic [c_CW-1:0] c_STALL_TH   = c_CW'(DEPTH - SLACK);
    // A pair may start only when both of its reads fit under MAX_OUT.
    localparam logic [c_OW-1:0] c_CREDIT_MAX = c_OW'(MAX_OUT - 2);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ISSUE_K = 2'd1;
    localparam logic [1:0] S_ISSUE_L = 2'd2;

    logic [ADDR_W-1:0] r_mem_k  [DEPTH];
    logic [ADDR_W-1:0] r_mem_l  [DEPTH];
    logic [TAG_W-1:0]  r_mem_rn [DEPTH];

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_OW-1:0] r_out;
    logic [1:0]      r_state;
    logic            r_err;

    logic [1:0]      w_state_next;
    logic [c_OW-1:0] w_out_next;
    logic            w_push;
    logic            w_pop;
    logic            w_fire;
    logic            w_sel;

    assign stall         = (r_count >= c_STALL_TH);
    assign w_push        = req_valid & ~stall;
    assign mem_req_valid = (r_state == S_ISSUE_K) | (r_state == S_ISSUE_L);
    assign w_sel         = (r_state == S_ISSUE_L);
    assign w_fire        = mem_req_valid & mem_req_ready;
    assign w_pop         = w_sel & mem_req_ready;

    // Head entry is read combinationally; it only changes on a pop, so the
    // request stays stable while the memory port is not ready.
    assign mem_req_addr  = mem_req_valid ? (w_sel ? r_mem_l[r_rd_ptr] : r_mem_k[r_rd_ptr])
                                         : '0;
    assign mem_req_tag   = mem_req_valid ? {r_mem_rn[r_rd_ptr], w_sel} : '0;

    assign fifo_count    = r_count;
    assign outstanding   = r_out;
    assign rsp_err       = r_err;
    assign busy          = (r_state != S_IDLE) | (r_count != '0) | (r_out != '0);

    // Request storage; payload needs no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_k[r_wr_ptr]  <= req_addr_k;
            r_mem_l[r_wr_ptr]  <= req_addr_l;
            r_mem_rn[r_wr_ptr] <= req_read_num;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CW'(1);
                2'b01:   r_count <= r_count - c_CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Next in-flight count: issue adds, response removes, never below zero.
    always_comb begin
        w_out_next = r_out;
        if (w_fire && !mem_rsp_valid) begin
            w_out_next = r_out + c_OW'(1);
        end else if (!w_fire && mem_rsp_valid && (r_out != '0)) begin
            w_out_next = r_out - c_OW'(1);
        end
    end

    // Issue sequencer: credit is checked only when a new pair starts.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if ((r_count != '0) && (r_out <= c_CREDIT_MAX)) w_state_next = S_ISSUE_K;
            end
            S_ISSUE_K: begin
                if (mem_req_ready) w_state_next = S_ISSUE_L;
            end
            S_ISSUE_L: begin
                if (mem_req_ready) begin
                    if (((r_count > c_CW'(1)) || w_push) && (w_out_next <= c_CREDIT_MAX))
                        w_state_next = S_ISSUE_K;
                    else
                        w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // State, credit counter and sticky response-underflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_out   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            if (mem_rsp_valid && (r_out == '0)) r_err <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kl_request_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_kl_request_scheduler
// Description : Self-checking bench for kl_request_scheduler: request table,
//               scoreboard of expected memory requests, and directed
//               sequences for hold, stall, credit, reset and error cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_kl_request_scheduler;

    localparam int AW = 42;
    localparam int TW = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [AW-1:0] req_addr_k = '0;
    logic [AW-1:0] req_addr_l = '0;
    logic [TW-1:0] req_read_num = '0;
    logic          stall;
    logic          mem_req_valid;
    logic          mem_req_ready = 1'b0;
    logic [AW-1:0] mem_req_addr;
    logic [TW:0]   mem_req_tag;
    logic          mem_rsp_valid = 1'b0;
    logic [4:0]    fifo_count;
    logic [2:0]    outstanding;
    logic          busy;
    logic          rsp_err;

    kl_request_scheduler #(
        .ADDR_W(AW), .TAG_W(TW), .DEPTH(16), .SLACK(2), .MAX_OUT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr_k(req_addr_k), .req_addr_l(req_addr_l),
        .req_read_num(req_read_num), .stall(stall),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_tag(mem_req_tag),
        .mem_rsp_valid(mem_rsp_valid), .fifo_count(fifo_count),
        .outstanding(outstanding), .busy(busy), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [TW:0]   tag;
    } exp_t;

    typedef struct {
        logic [AW-1:0] k;
        logic [AW-1:0] l;
        logic [TW-1:0] rn;
        logic [AW-1:0] ek;
        logic [AW-1:0] el;
        logic [TW:0]   tk;
        logic [TW:0]   tl;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[4];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   hs_n  = 0;
    int   hs_first = 0;
    int   hs_last  = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One request cycle; expected pair goes on the scoreboard if accepted.
    task automatic push(input logic [AW-1:0] k, input logic [AW-1:0] l, input logic [TW-1:0] rn,
                        input logic [AW-1:0] ek, input logic [AW-1:0] el,
                        input logic [TW:0] tk, input logic [TW:0] tl);
        req_valid    = 1'b1;
        req_addr_k   = k;
        req_addr_l   = l;
        req_read_num = rn;
        if (!stall) begin
            exp_q.push_back('{addr: ek, tag: tk});
            exp_q.push_back('{addr: el, tag: tl});
        end
        tick(1);
        req_valid = 1'b0;
    endtask

    task automatic push_simple(input logic [AW-1:0] k, input logic [AW-1:0] l, input logic [TW-1:0] rn);
        push(k, l, rn, k, l, {rn, 1'b0}, {rn, 1'b1});
    endtask

    // Run with an auto-responder until every expected request has been seen.
    task automatic drain(input int max_cyc, input string nm);
        int n = 0;
        while (((exp_q.size() != 0) || (outstanding != 3'd0)) && (n < max_cyc)) begin
            mem_rsp_valid = (outstanding != 3'd0);
            tick(1);
            n++;
        end
        mem_rsp_valid = 1'b0;
        check(nm, 64'(n < max_cyc), 64'd1);
    endtask

    // Scoreboard: every accepted memory request must match the next expected one.
    always @(negedge clk) begin
        exp_t e;
        cyc++;
        if (!rst && mem_req_valid && mem_req_ready) begin
            hs_n++;
            if (hs_n == 1) hs_first = cyc;
            hs_last = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got addr 0x%0h tag 0x%0h want no request",
                         mem_req_addr, mem_req_tag);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", 64'(mem_req_addr), 64'(e.addr));
                check("sb_tag",  64'(mem_req_tag),  64'(e.tag));
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int model;
        vecs[0] = '{k: 42'h000_0000_0ABC, l: 42'h3FF_FFFF_FFFF, rn: 9'h1FF,
                    ek: 42'h000_0000_0ABC, el: 42'h3FF_FFFF_FFFF, tk: 10'h3FE, tl: 10'h3FF};
        vecs[1] = '{k: 42'h0, l: 42'h1, rn: 9'h000,
                    ek: 42'h0, el: 42'h1, tk: 10'h000, tl: 10'h001};
        vecs[2] = '{k: 42'h012_3456_789A, l: 42'h00A_BCDE_F012, rn: 9'h0A5,
                    ek: 42'h012_3456_789A, el: 42'h00A_BCDE_F012, tk: 10'h14A, tl: 10'h14B};
        vecs[3] = '{k: 42'h2AA_AAAA_AAAA, l: 42'h155_5555_5555, rn: 9'h100,
                    ek: 42'h2AA_AAAA_AAAA, el: 42'h155_5555_5555, tk: 10'h200, tl: 10'h201};

        // Reset state
        tick(3);
        check("rst_flags", {mem_req_valid, stall, busy, rsp_err, fifo_count, outstanding}, 64'd0);
        check("rst_addr", 64'(mem_req_addr), 64'd0);
        rst = 1'b0;
        mem_req_ready = 1'b1;
        tick(1);

        // Single request latency and pair ordering
        push_simple(42'h1, 42'h2, 9'd5);
        check("t1_idle_t1", 64'(mem_req_valid), 64'd0);
        tick(1);
        check("t1_k", {mem_req_valid, mem_req_addr, mem_req_tag}, {1'b1, 42'h1, 10'd10});
        tick(1);
        check("t1_l", {mem_req_valid, mem_req_addr, mem_req_tag}, {1'b1, 42'h2, 10'd11});
        tick(1);
        check("t1_done", {mem_req_valid, outstanding}, {1'b0, 3'd2});
        mem_rsp_valid = 1'b1;
        tick(2);
        mem_rsp_valid = 1'b0;
        check("t1_quiet", {busy, outstanding}, 64'd0);

        // Table: back-to-back pairs must issue on consecutive cycles
        for (int i = 0; i < 4; i += 2) begin
            hs_n = 0;
            push(vecs[i].k, vecs[i].l, vecs[i].rn, vecs[i].ek, vecs[i].el, vecs[i].tk, vecs[i].tl);
            push(vecs[i+1].k, vecs[i+1].l, vecs[i+1].rn,
                 vecs[i+1].ek, vecs[i+1].el, vecs[i+1].tk, vecs[i+1].tl);
            tick(6);
            check("tbl_count", 64'(hs_n), 64'd4);
            check("tbl_nogap", 64'(hs_last - hs_first), 64'd3);
            check("tbl_out", 64'(outstanding), 64'd4);
            drain(50, "tbl_drain");
        end

        // Memory not ready: request held constant, nothing popped
        mem_req_ready = 1'b0;
        push_simple(42'h77, 42'h88, 9'd3);
        tick(1);
        for (int i = 0; i < 5; i++) begin
            check("t2_hold", {mem_req_valid, mem_req_addr, mem_req_tag}, {1'b1, 42'h77, 10'd6});
            tick(1);
        end
        check("t2_count", 64'(fifo_count), 64'd1);
        mem_req_ready = 1'b1;
        drain(50, "t2_drain");

        // Fill up to the stall threshold with memory blocked
        mem_req_ready = 1'b0;
        model = 0;
        for (int i = 0; i < 20; i++) begin
            check("t3_stall", 64'(stall), 64'(model >= 14));
            req_valid    = 1'b1;
            req_addr_k   = AW'(i) + 42'h100;
            req_addr_l   = AW'(i) + 42'h200;
            req_read_num = TW'(i);
            if (!stall) begin
                exp_q.push_back('{addr: AW'(i) + 42'h100, tag: {TW'(i), 1'b0}});
                exp_q.push_back('{addr: AW'(i) + 42'h200, tag: {TW'(i), 1'b1}});
                model++;
            end
            tick(1);
        end
        req_valid = 1'b0;
        check("t3_count", 64'(fifo_count), 64'd14);
        check("t3_sb", 64'(exp_q.size()), 64'd28);
        mem_req_ready = 1'b1;
        drain(400, "t3_drain");
        check("t3_unstall", 64'(stall), 64'd0);

        // Credit limit of four outstanding reads
        hs_n = 0;
        push_simple(42'h10, 42'h11, 9'd1);
        push_simple(42'h20, 42'h21, 9'd2);
        push_simple(42'h30, 42'h31, 9'd3);
        tick(10);
        check("t4_capped", {fifo_count, outstanding, mem_req_valid}, {5'd1, 3'd4, 1'b0});
        check("t4_hs4", 64'(hs_n), 64'd4);
        mem_rsp_valid = 1'b1;
        tick(1);
        mem_rsp_valid = 1'b0;
        tick(5);
        check("t4_wait", {32'(hs_n), 29'd0, outstanding}, {32'd4, 29'd0, 3'd3});
        mem_rsp_valid = 1'b1;
        tick(1);
        mem_rsp_valid = 1'b0;
        tick(6);
        check("t4_resume", {32'(hs_n), 29'd0, outstanding}, {32'd6, 29'd0, 3'd4});
        drain(50, "t4_drain");
        check("t4_noerr", 64'(rsp_err), 64'd0);

        // Asynchronous reset while in ISSUE_L
        mem_req_ready = 1'b0;
        for (int i = 0; i < 6; i++) push_simple(AW'(i) + 42'h500, AW'(i) + 42'h600, TW'(i + 40));
        mem_req_ready = 1'b1;
        tick(3);
        mem_req_ready = 1'b0;
        check("t5_pre", {fifo_count, outstanding, mem_req_valid}, {5'd5, 3'd3, 1'b1});
        check("t5_pre_tag", 64'(mem_req_tag), {53'd0, 9'd41, 1'b1});
        #2;
        rst = 1'b1;
        #1;
        check("t5_rst_flags", {mem_req_valid, stall, busy, rsp_err, fifo_count, outstanding}, 64'd0);
        check("t5_rst_bus", {mem_req_addr, mem_req_tag}, 64'd0);
        exp_q.delete();
        hs_n = 0;
        tick(2);
        rst = 1'b0;
        mem_req_ready = 1'b1;
        tick(10);
        check("t5_silent", {32'(hs_n), 30'd0, mem_req_valid, busy}, 64'd0);
        push_simple(42'hABC, 42'hDEF, 9'd7);
        drain(50, "t5_drain");

        // Response with nothing outstanding
        mem_rsp_valid = 1'b1;
        tick(1);
        mem_rsp_valid = 1'b0;
        check("t6_err", {rsp_err, outstanding}, {1'b1, 3'd0});
        tick(3);
        check("t6_sticky", {rsp_err, outstanding}, {1'b1, 3'd0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
